multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore/Mealy control FSM for the multicycle RV32I core. It consumes the opcode and branch/memory status from the multicycle datapath and produces every CTL_* strobe that sequences fetch, decode, execute, memory and writeback. It adds a memory-ready handshake with a timeout, and a sticky trap on illegal opcodes or bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, maximum wait cycles for mem_ready in any memory state; 0 disables the timeout.
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the wait counter.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
opcode  input  7  IR[6:0] from datapath
branch_taken  input  1  branch_unit result, valid while CTL_PCWriteCond=1
mem_ready  input  1  memory completes the current read/write this cycle
CTL_IorD  output  1  0=PC address, 1=ALUOut address
CTL_MemRead  output  1  memory read request
CTL_MemWrite  output  1  memory write request
CTL_IRWrite  output  1  load IR
CTL_RegWrite  output  1  regfile write
CTL_MemToReg  output  2  0=ALUOut, 1=MDR, 2=PC+4
CTL_PCSrc  output  2  0=alu_result, 1=ALUOut, 2=alu_result&~1
CTL_PCWriteCond  output  1  branch-evaluate enable
CTL_PCWrite  output  1  unconditional PC write
CTL_ALUSrcA  output  2  0=PC, 1=A, 2=zero
CTL_ALUSrcB  output  3  0=B, 1=4, 2=imm, 3=imm<<1, 4=zero
CTL_ALUOp  output  aluop_t  ALUOP_ADD / ALUOP_FUNC (R-type) / ALUOP_IMM (I-type)
instr_retired  output  1  one-cycle pulse on the cycle the PC is written at instruction end
illegal_instr  output  1  sticky: trap caused by an illegal or SYSTEM opcode
bus_error  output  1  sticky: trap caused by a mem_ready timeout
state_dbg  output  4  current state encoding

Behaviour:
- Default for every output is 0 / ALUOP_ADD. Unlisted signals in a state take the default.
- While reset=1, all outputs are forced to their defaults. At the next edge: state=FETCH, counter=0, sticky flags=0.
- A reset asserted mid-instruction aborts it. No register, PC or memory write occurs after the reset edge.
- The PC is held through the whole instruction and written only in the final state, which always asserts instr_retired.
- FETCH: IorD=0, MemRead=1. IRWrite=mem_ready. If mem_ready, go to DECODE; otherwise stay.
- DECODE: no enables; A/B latch. Next state by opcode:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0110111 -> EXEC_LUI
  - 0010111 -> EXEC_AUIPC
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0001111 (FENCE) -> PCINC
  - anything else, including 1110011 -> TRAP with illegal_instr=1
- MEMADR: SrcA=1, SrcB=2. Next state: MEMRD for a load, MEMWR for a store.
- MEMRD: IorD=1, MemRead=1, SrcA=1, SrcB=2 so ALUOut stays stable. On mem_ready go to MEMWB.
- MEMWR: IorD=1, MemWrite=1, SrcA=1, SrcB=2. On mem_ready go to PCINC.
- Memory requests and address selects stay constant while waiting.
- Timeout: the counter increments each cycle in FETCH/MEMRD/MEMWR without mem_ready and clears on state change. When it reaches TIMEOUT_CYCLES without mem_ready, go to TRAP with bus_error=1.
- EXEC_R: SrcA=1, SrcB=0, ALUOp=FUNC.
- EXEC_I: SrcA=1, SrcB=2, ALUOp=IMM.
- EXEC_LUI: SrcA=2, SrcB=2.
- EXEC_AUIPC: SrcA=0, SrcB=2.
- All four EXEC states go to ALUWB.
- Final states: each asserts PCWrite=1 and instr_retired=1, then goes to FETCH.
  - ALUWB: RegWrite=1, MemToReg=0, SrcA=0, SrcB=1, PCSrc=0.
  - MEMWB: RegWrite=1, MemToReg=1, SrcA=0, SrcB=1, PCSrc=0.
  - PCINC: SrcA=0, SrcB=1, PCSrc=0.
  - BRANCH: PCWriteCond=1, SrcA=0, PCSrc=0. SrcB=3 if branch_taken else 1. This select is Mealy, combinational from branch_taken.
  - JAL: RegWrite=1, MemToReg=2, SrcA=0, SrcB=3, PCSrc=0.
  - JALR: RegWrite=1, MemToReg=2, SrcA=1, SrcB=2, PCSrc=2.
- TRAP: all enables 0. The FSM holds until reset; sticky flags hold.
- Cycle counts per instruction, with a zero-wait memory:
  - ALU ops (R, I, LUI, AUIPC): 4
  - Branch, JAL, JALR, FENCE: 3
  - Load: 5
  - Store: 5
- Each mem wait cycle adds 1.
- Write-enable exclusivity: MemRead, MemWrite and RegWrite are never high together. At most one of IRWrite, MemWrite and RegWrite is high in any cycle.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with mem_ready=1 -> states FETCH,DECODE,EXEC_I,ALUWB; RegWrite one cycle; instr_retired at cycle 4; PCWrite only in ALUWB.
- LW with mem_ready low for 3 cycles in MEMRD -> MemRead/IorD=1 held 4 cycles, no IRWrite; MEMWB has MemToReg=1; 8 cycles total.
- BEQ with branch_taken=1, then with branch_taken=0 -> BRANCH drives ALUSrcB=3 or 1 respectively; PCWriteCond=1, PCWrite=1; 3 cycles each.
- JALR -> JALR state asserts RegWrite, MemToReg=2, PCSrc=2, ALUSrcA=1, ALUSrcB=2 in the same cycle.
- opcode 0x73 (ECALL), and separately opcode 0x7F -> TRAP, illegal_instr=1, all enables 0 for 20 cycles; reset clears to FETCH.
- TIMEOUT_CYCLES=4, mem_ready stuck low in FETCH -> TRAP after 4 wait cycles, bus_error=1. Reset asserted mid-MEMWR -> no further MemWrite; next state FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// strobes, with a mem_ready timeout and sticky traps for illegal opcodes and bus timeouts.
package multicycle_control_pkg;
   typedef enum logic [1:0] {
      ALUOP_ADD  = 2'd0,
      ALUOP_FUNC = 2'd1,
      ALUOP_IMM  = 2'd2
   } aluop_t;
endpackage

module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       CTL_IorD,
   output logic       CTL_MemRead,
   output logic       CTL_MemWrite,
   output logic       CTL_IRWrite,
   output logic       CTL_RegWrite,
   output logic [1:0] CTL_MemToReg,
   output logic [1:0] CTL_PCSrc,
   output logic       CTL_PCWriteCond,
   output logic       CTL_PCWrite,
   output logic [1:0] CTL_ALUSrcA,
   output logic [2:0] CTL_ALUSrcB,
   output aluop_t     CTL_ALUOp,
   output logic       instr_retired,
   output logic       illegal_instr,
   output logic       bus_error,
   output logic [3:0] state_dbg
);

   // A zero timeout yields a zero-width counter; keep at least one bit.
   localparam int CW = (CNT_W > 0) ? CNT_W : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [3:0] {
      FETCH      = 4'd0,
      DECODE     = 4'd1,
      MEMADR     = 4'd2,
      MEMRD      = 4'd3,
      MEMWR      = 4'd4,
      MEMWB      = 4'd5,
      EXEC_R     = 4'd6,
      EXEC_I     = 4'd7,
      EXEC_LUI   = 4'd8,
      EXEC_AUIPC = 4'd9,
      ALUWB      = 4'd10,
      BRANCH     = 4'd11,
      JAL        = 4'd12,
      JALR       = 4'd13,
      PCINC      = 4'd14,
      TRAP       = 4'd15
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            illegal_q, illegal_d;
   logic            bus_err_q, bus_err_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         FETCH, MEMRD, MEMWR: begin
            if (mem_ready) begin
               case (state_q)
                  FETCH:   state_d = DECODE;
                  MEMRD:   state_d = MEMWB;
                  default: state_d = PCINC;
               endcase
            end else if (TIMEOUT_CYCLES != 0) begin
               if (cnt_q == CNT_LAST) begin
                  state_d   = TRAP;
                  bus_err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXEC_R;
               OP_ITYPE:          state_d = EXEC_I;
               OP_LUI:            state_d = EXEC_LUI;
               OP_AUIPC:          state_d = EXEC_AUIPC;
               OP_BRANCH:         state_d = BRANCH;
               OP_JAL:            state_d = JAL;
               OP_JALR:           state_d = JALR;
               OP_FENCE:          state_d = PCINC;
               default: begin
                  state_d   = TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR:                             state_d = (opcode == OP_STORE) ? MEMWR : MEMRD;
         EXEC_R, EXEC_I, EXEC_LUI, EXEC_AUIPC: state_d = ALUWB;
         ALUWB, MEMWB, PCINC, BRANCH, JAL, JALR: state_d = FETCH;
         TRAP:                               state_d = TRAP;
         default:                            state_d = TRAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Strobes decode from the registered state; reset masks everything, including the flags.
   always_comb begin
      CTL_IorD        = 1'b0;
      CTL_MemRead     = 1'b0;
      CTL_MemWrite    = 1'b0;
      CTL_IRWrite     = 1'b0;
      CTL_RegWrite    = 1'b0;
      CTL_MemToReg    = 2'd0;
      CTL_PCSrc       = 2'd0;
      CTL_PCWriteCond = 1'b0;
      CTL_PCWrite     = 1'b0;
      CTL_ALUSrcA     = 2'd0;
      CTL_ALUSrcB     = 3'd0;
      CTL_ALUOp       = ALUOP_ADD;
      instr_retired   = 1'b0;
      illegal_instr   = 1'b0;
      bus_error       = 1'b0;
      state_dbg       = '0;
      if (!reset) begin
         illegal_instr = illegal_q;
         bus_error     = bus_err_q;
         state_dbg     = state_q;
         case (state_q)
            FETCH: begin
               CTL_MemRead = 1'b1;
               CTL_IRWrite = mem_ready;
            end
            MEMADR: begin
               CTL_ALUSrcA = 2'd1;
               CTL_ALUSrcB = 3'd2;
            end
            MEMRD: begin
               CTL_IorD    = 1'b1;
               CTL_MemRead = 1'b1;
               CTL_ALUSrcA = 2'd1;
               CTL_ALUSrcB = 3'd2;
            end
            MEMWR: begin
               CTL_IorD     = 1'b1;
               CTL_MemWrite = 1'b1;
               CTL_ALUSrcA  = 2'd1;
               CTL_ALUSrcB  = 3'd2;
            end
            EXEC_R: begin
               CTL_ALUSrcA = 2'd1;
               CTL_ALUSrcB = 3'd0;
               CTL_ALUOp   = ALUOP_FUNC;
            end
            EXEC_I: begin
               CTL_ALUSrcA = 2'd1;
               CTL_ALUSrcB = 3'd2;
               CTL_ALUOp   = ALUOP_IMM;
            end
            EXEC_LUI: begin
               CTL_ALUSrcA = 2'd2;
               CTL_ALUSrcB = 3'd2;
            end
            EXEC_AUIPC: begin
               CTL_ALUSrcA = 2'd0;
               CTL_ALUSrcB = 3'd2;
            end
            ALUWB: begin
               CTL_RegWrite  = 1'b1;
               CTL_ALUSrcB   = 3'd1;
               CTL_PCWrite   = 1'b1;
               instr_retired = 1'b1;
            end
            MEMWB: begin
               CTL_RegWrite  = 1'b1;
               CTL_MemToReg  = 2'd1;
               CTL_ALUSrcB   = 3'd1;
               CTL_PCWrite   = 1'b1;
               instr_retired = 1'b1;
            end
            PCINC: begin
               CTL_ALUSrcB   = 3'd1;
               CTL_PCWrite   = 1'b1;
               instr_retired = 1'b1;
            end
            BRANCH: begin
               CTL_PCWriteCond = 1'b1;
               CTL_ALUSrcB     = branch_taken ? 3'd3 : 3'd1;
               CTL_PCWrite     = 1'b1;
               instr_retired   = 1'b1;
            end
            JAL: begin
               CTL_RegWrite  = 1'b1;
               CTL_MemToReg  = 2'd2;
               CTL_ALUSrcB   = 3'd3;
               CTL_PCWrite   = 1'b1;
               instr_retired = 1'b1;
            end
            JALR: begin
               CTL_RegWrite  = 1'b1;
               CTL_MemToReg  = 2'd2;
               CTL_ALUSrcA   = 2'd1;
               CTL_ALUSrcB   = 3'd2;
               CTL_PCSrc     = 2'd2;
               CTL_PCWrite   = 1'b1;
               instr_retired = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: planned cycles push expected strobe vectors,
// which are popped and compared against the DUT one cycle at a time.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWR = 4,
                  S_MEMWB = 5, S_EXEC_R = 6, S_EXEC_I = 7, S_EXEC_LUI = 8, S_EXEC_AUIPC = 9,
                  S_ALUWB = 10, S_BRANCH = 11, S_JAL = 12, S_JALR = 13, S_PCINC = 14, S_TRAP = 15;

   typedef struct {
      logic [6:0] op;
      int         st;
      bit         mr;
      bit         bt;
      bit         ill;
      bit         be;
      bit         rst;
   } cyc_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1, mem_ready = 1'b0, branch_taken = 1'b0;
   logic [6:0] opcode = '0;
   logic       reset2 = 1'b1, mem_ready2 = 1'b0;
   logic [6:0] opcode2 = '0;

   logic iord, mrd, mwr, irw, rw, pwc, pw, ret, ill, be;
   logic [1:0] m2r, pcs, sa, aop_bits;
   logic [2:0] sb;
   logic [3:0] sd;
   aluop_t aop;
   logic iord2, mrd2, mwr2, irw2, rw2, pwc2, pw2, ret2, ill2, be2;
   logic [1:0] m2r2, pcs2, sa2, aop_bits2;
   logic [2:0] sb2;
   logic [3:0] sd2;
   aluop_t aop2;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
      .CTL_IorD(iord), .CTL_MemRead(mrd), .CTL_MemWrite(mwr), .CTL_IRWrite(irw), .CTL_RegWrite(rw),
      .CTL_MemToReg(m2r), .CTL_PCSrc(pcs), .CTL_PCWriteCond(pwc), .CTL_PCWrite(pw),
      .CTL_ALUSrcA(sa), .CTL_ALUSrcB(sb), .CTL_ALUOp(aop), .instr_retired(ret),
      .illegal_instr(ill), .bus_error(be), .state_dbg(sd)
   );

   multicycle_control #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .reset(reset2), .opcode(opcode2), .branch_taken(branch_taken), .mem_ready(mem_ready2),
      .CTL_IorD(iord2), .CTL_MemRead(mrd2), .CTL_MemWrite(mwr2), .CTL_IRWrite(irw2), .CTL_RegWrite(rw2),
      .CTL_MemToReg(m2r2), .CTL_PCSrc(pcs2), .CTL_PCWriteCond(pwc2), .CTL_PCWrite(pw2),
      .CTL_ALUSrcA(sa2), .CTL_ALUSrcB(sb2), .CTL_ALUOp(aop2), .instr_retired(ret2),
      .illegal_instr(ill2), .bus_error(be2), .state_dbg(sd2)
   );

   assign aop_bits  = aop;
   assign aop_bits2 = aop2;

   logic [24:0] obs, obs2;
   assign obs  = {sd, iord, mrd, mwr, irw, rw, m2r, pcs, pwc, pw, sa, sb, aop_bits, ret, ill, be};
   assign obs2 = {sd2, iord2, mrd2, mwr2, irw2, rw2, m2r2, pcs2, pwc2, pw2, sa2, sb2, aop_bits2,
                  ret2, ill2, be2};

   cyc_t        plan[$];
   logic [24:0] scb[$];
   int          total = 0;
   int          bad = 0;

   function automatic logic [24:0] exp_ctl(int st, bit mr, bit bt, bit fl_ill, bit fl_be);
      logic e_iord, e_mrd, e_mwr, e_irw, e_rw, e_pwc, e_pw, e_ret;
      logic [1:0] e_m2r, e_pcs, e_sa, e_aop;
      logic [2:0] e_sb;
      {e_iord, e_mrd, e_mwr, e_irw, e_rw, e_pwc, e_pw, e_ret} = '0;
      e_m2r = 2'd0; e_pcs = 2'd0; e_sa = 2'd0; e_sb = 3'd0; e_aop = ALUOP_ADD;
      case (st)
         S_FETCH:      begin e_mrd = 1; e_irw = mr; end
         S_MEMADR:     begin e_sa = 1; e_sb = 2; end
         S_MEMRD:      begin e_iord = 1; e_mrd = 1; e_sa = 1; e_sb = 2; end
         S_MEMWR:      begin e_iord = 1; e_mwr = 1; e_sa = 1; e_sb = 2; end
         S_EXEC_R:     begin e_sa = 1; e_sb = 0; e_aop = ALUOP_FUNC; end
         S_EXEC_I:     begin e_sa = 1; e_sb = 2; e_aop = ALUOP_IMM; end
         S_EXEC_LUI:   begin e_sa = 2; e_sb = 2; end
         S_EXEC_AUIPC: begin e_sa = 0; e_sb = 2; end
         S_ALUWB:      begin e_rw = 1; e_sb = 1; e_pw = 1; e_ret = 1; end
         S_MEMWB:      begin e_rw = 1; e_m2r = 1; e_sb = 1; e_pw = 1; e_ret = 1; end
         S_PCINC:      begin e_sb = 1; e_pw = 1; e_ret = 1; end
         S_BRANCH:     begin e_pwc = 1; e_sb = bt ? 3 : 1; e_pw = 1; e_ret = 1; end
         S_JAL:        begin e_rw = 1; e_m2r = 2; e_sb = 3; e_pw = 1; e_ret = 1; end
         S_JALR:       begin e_rw = 1; e_m2r = 2; e_sa = 1; e_sb = 2; e_pcs = 2; e_pw = 1; e_ret = 1; end
         default: ;
      endcase
      return {4'(st), e_iord, e_mrd, e_mwr, e_irw, e_rw, e_m2r, e_pcs, e_pwc, e_pw, e_sa, e_sb,
              e_aop, e_ret, fl_ill, fl_be};
   endfunction

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic void add(logic [6:0] op, int st, bit mr, bit bt,
                               bit fl_ill = 0, bit fl_be = 0, bit rst = 0);
      cyc_t c;
      c.op = op; c.st = st; c.mr = mr; c.bt = bt; c.ill = fl_ill; c.be = fl_be; c.rst = rst;
      plan.push_back(c);
   endfunction

   // Expected state walk for one instruction, built from the opcode alone.
   function automatic void plan_instr(logic [6:0] op, bit bt, int wf, int wm);
      for (int i = 0; i < wf; i++) add(op, S_FETCH, 0, rb());
      add(op, S_FETCH, 1, rb());
      add(op, S_DECODE, rb(), rb());
      case (op)
         7'h03: begin
            add(op, S_MEMADR, rb(), rb());
            for (int i = 0; i < wm; i++) add(op, S_MEMRD, 0, rb());
            add(op, S_MEMRD, 1, rb());
            add(op, S_MEMWB, rb(), rb());
         end
         7'h23: begin
            add(op, S_MEMADR, rb(), rb());
            for (int i = 0; i < wm; i++) add(op, S_MEMWR, 0, rb());
            add(op, S_MEMWR, 1, rb());
            add(op, S_PCINC, rb(), rb());
         end
         7'h33: begin add(op, S_EXEC_R, rb(), rb());     add(op, S_ALUWB, rb(), rb()); end
         7'h13: begin add(op, S_EXEC_I, rb(), rb());     add(op, S_ALUWB, rb(), rb()); end
         7'h37: begin add(op, S_EXEC_LUI, rb(), rb());   add(op, S_ALUWB, rb(), rb()); end
         7'h17: begin add(op, S_EXEC_AUIPC, rb(), rb()); add(op, S_ALUWB, rb(), rb()); end
         7'h63: add(op, S_BRANCH, rb(), bt);
         7'h6F: add(op, S_JAL, rb(), rb());
         7'h67: add(op, S_JALR, rb(), rb());
         7'h0F: add(op, S_PCINC, rb(), rb());
         default: add(op, S_TRAP, rb(), rb(), 1);
      endcase
   endfunction

   task automatic test_reset();
      cyc_t c; logic [24:0] want; int n = 0;
      add(7'h33, S_FETCH, 1, 1, 0, 0, 1);
      add(7'h33, S_FETCH, 1, 1, 0, 0, 1);
      add(7'h00, S_FETCH, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(negedge clk);
         reset = c.rst; opcode = c.op; mem_ready = c.mr; branch_taken = c.bt;
         scb.push_back(c.rst ? 25'd0 : exp_ctl(c.st, c.mr, c.bt, c.ill, c.be));
         #1; want = scb.pop_front(); total++;
         if (obs !== want) begin bad++; $display("FAIL reset cyc=%0d got=%h want=%h", n, obs, want); end
         n++;
      end
   endtask

   task automatic test_addi();
      cyc_t c; logic [24:0] want; int n = 0;
      plan_instr(7'h13, 0, 0, 0);
      add(7'h13, S_FETCH, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(negedge clk);
         reset = c.rst; opcode = c.op; mem_ready = c.mr; branch_taken = c.bt;
         scb.push_back(c.rst ? 25'd0 : exp_ctl(c.st, c.mr, c.bt, c.ill, c.be));
         #1; want = scb.pop_front(); total++;
         if (obs !== want) begin bad++; $display("FAIL addi cyc=%0d got=%h want=%h", n, obs, want); end
         n++;
      end
   endtask

   task automatic test_load_wait();
      cyc_t c; logic [24:0] want; int n = 0;
      plan_instr(7'h03, 0, 0, 3);
      plan_instr(7'h03, 0, 2, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(negedge clk);
         reset = c.rst; opcode = c.op; mem_ready = c.mr; branch_taken = c.bt;
         scb.push_back(c.rst ? 25'd0 : exp_ctl(c.st, c.mr, c.bt, c.ill, c.be));
         #1; want = scb.pop_front(); total++;
         if (obs !== want) begin bad++; $display("FAIL load_wait cyc=%0d got=%h want=%h", n, obs, want); end
         n++;
      end
   endtask

   task automatic test_branch_jump();
      cyc_t c; logic [24:0] want; int n = 0;
      plan_instr(7'h63, 1, 0, 0);
      plan_instr(7'h63, 0, 0, 0);
      plan_instr(7'h67, 0, 0, 0);
      plan_instr(7'h6F, 0, 1, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(negedge clk);
         reset = c.rst; opcode = c.op; mem_ready = c.mr; branch_taken = c.bt;
         scb.push_back(c.rst ? 25'd0 : exp_ctl(c.st, c.mr, c.bt, c.ill, c.be));
         #1; want = scb.pop_front(); total++;
         if (obs !== want) begin bad++; $display("FAIL branch_jump cyc=%0d got=%h want=%h", n, obs, want); end
         n++;
      end
   endtask

   task automatic test_back_to_back();
      cyc_t c; logic [24:0] want; int n = 0;
      plan_instr(7'h23, 0, 0, 0);
      plan_instr(7'h0F, 0, 0, 0);
      plan_instr(7'h37, 0, 0, 0);
      plan_instr(7'h17, 0, 0, 0);
      plan_instr(7'h33, 0, 0, 0);
      plan_instr(7'h23, 0, 0, 2);
      plan_instr(7'h03, 0, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(negedge clk);
         reset = c.rst; opcode = c.op; mem_ready = c.mr; branch_taken = c.bt;
         scb.push_back(c.rst ? 25'd0 : exp_ctl(c.st, c.mr, c.bt, c.ill, c.be));
         #1; want = scb.pop_front(); total++;
         if (obs !== want) begin bad++; $display("FAIL back_to_back cyc=%0d got=%h want=%h", n, obs, want); end
         n++;
      end
   endtask

   task automatic test_illegal();
      cyc_t c; logic [24:0] want; int n = 0;
      plan_instr(7'h73, 0, 0, 0);
      for (int i = 0; i < 19; i++) add(7'h73, S_TRAP, rb(), rb(), 1);
      add(7'h73, S_FETCH, rb(), rb(), 0, 0, 1);
      plan_instr(7'h7F, 0, 0, 0);
      for (int i = 0; i < 19; i++) add(7'h7F, S_TRAP, rb(), rb(), 1);
      add(7'h7F, S_FETCH, rb(), rb(), 0, 0, 1);
      add(7'h00, S_FETCH, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(negedge clk);
         reset = c.rst; opcode = c.op; mem_ready = c.mr; branch_taken = c.bt;
         scb.push_back(c.rst ? 25'd0 : exp_ctl(c.st, c.mr, c.bt, c.ill, c.be));
         #1; want = scb.pop_front(); total++;
         if (obs !== want) begin bad++; $display("FAIL illegal cyc=%0d got=%h want=%h", n, obs, want); end
         n++;
      end
   endtask

   task automatic test_mid_reset();
      cyc_t c; logic [24:0] want; int n = 0;
      add(7'h23, S_FETCH, 1, 0);
      add(7'h23, S_DECODE, 0, 0);
      add(7'h23, S_MEMADR, 0, 0);
      add(7'h23, S_MEMWR, 0, 0);
      add(7'h23, S_MEMWR, 0, 0);
      add(7'h23, S_FETCH, 1, 0, 0, 0, 1);
      add(7'h23, S_FETCH, 0, 0);
      plan_instr(7'h13, 0, 0, 0);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(negedge clk);
         reset = c.rst; opcode = c.op; mem_ready = c.mr; branch_taken = c.bt;
         scb.push_back(c.rst ? 25'd0 : exp_ctl(c.st, c.mr, c.bt, c.ill, c.be));
         #1; want = scb.pop_front(); total++;
         if (obs !== want) begin bad++; $display("FAIL mid_reset cyc=%0d got=%h want=%h", n, obs, want); end
         n++;
      end
   endtask

   // Timeout instance: four idle waits trap, three waits followed by ready do not.
   task automatic test_timeout();
      cyc_t c; logic [24:0] want; int n = 0;
      add(7'h03, S_FETCH, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) add(7'h03, S_FETCH, 0, rb());
      for (int i = 0; i < 3; i++) add(7'h03, S_TRAP, rb(), rb(), 0, 1);
      add(7'h03, S_FETCH, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) add(7'h03, S_FETCH, 0, rb());
      add(7'h03, S_FETCH, 1, rb());
      add(7'h03, S_DECODE, rb(), rb());
      add(7'h03, S_MEMADR, rb(), rb());
      for (int i = 0; i < 4; i++) add(7'h03, S_MEMRD, 0, rb());
      for (int i = 0; i < 2; i++) add(7'h03, S_TRAP, rb(), rb(), 0, 1);
      add(7'h23, S_FETCH, 0, 0, 0, 0, 1);
      plan_instr(7'h23, 0, 0, 3);
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(negedge clk);
         reset2 = c.rst; opcode2 = c.op; mem_ready2 = c.mr; branch_taken = c.bt;
         scb.push_back(c.rst ? 25'd0 : exp_ctl(c.st, c.mr, c.bt, c.ill, c.be));
         #1; want = scb.pop_front(); total++;
         if (obs2 !== want) begin bad++; $display("FAIL timeout cyc=%0d got=%h want=%h", n, obs2, want); end
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_addi();
      test_load_wait();
      test_branch_jump();
      test_back_to_back();
      test_illegal();
      test_mid_reset();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
